// File: rtl/mips_cpu_multiplier_if.sv
// Operand/result bundle between the ALU (master) and the iterative multiplier (slave).
interface mips_cpu_multiplier_if;
  logic        start;
  logic        sign;
  logic [31:0] Multiplicand;
  logic [31:0] Multiplier;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        busy;
  logic        done;

  modport master (
    output start, sign, Multiplicand, Multiplier,
    input  Hi, Lo, busy, done
  );

  modport slave (
    input  start, sign, Multiplicand, Multiplier,
    output Hi, Lo, busy, done
  );
endinterface

// File: rtl/mips_cpu_multiplier.sv
// Iterative shift-add multiplier for MULT/MULTU. One multiplier bit is retired
// per cycle on operand magnitudes; the sign is applied once at completion.
// Optional macro MIPS_CPU_MULT_EARLY_EXIT_EN: finish as soon as no set
// multiplier bits remain instead of always running 32 iterations.
module mips_cpu_multiplier (
  input  logic                       clk,
  input  logic                       reset,
  mips_cpu_multiplier_if.slave       bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] mplr;
  logic [4:0]  cnt;
  logic        neg;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;

  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        neg_in;
  logic        zero_op;
  logic [63:0] acc_sum;
  logic [31:0] mplr_shift;
  logic        last;
  logic [63:0] product;

  // Operand magnitudes and result sign taken at start; -2^31 stays 0x8000_0000.
  always_comb begin
    mag_a   = (bus.sign && bus.Multiplicand[31]) ? (~bus.Multiplicand + 32'd1) : bus.Multiplicand;
    mag_b   = (bus.sign && bus.Multiplier[31])   ? (~bus.Multiplier + 32'd1)   : bus.Multiplier;
    neg_in  = bus.sign & (bus.Multiplicand[31] ^ bus.Multiplier[31]);
    zero_op = (bus.Multiplicand == 32'd0) || (bus.Multiplier == 32'd0);
  end

  // One iteration's add/shift and the completion test, including this cycle's add.
  always_comb begin
    acc_sum    = mplr[0] ? (acc + mcand) : acc;
    mplr_shift = mplr >> 1;
`ifdef MIPS_CPU_MULT_EARLY_EXIT_EN
    last       = (cnt == 5'd31) || (mplr_shift == 32'd0);
`else
    last       = (cnt == 5'd31);
`endif
    product    = neg ? (~acc_sum + 64'd1) : acc_sum;
  end

  // Control FSM and datapath; reset beats start, start beats an in-flight run.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= 64'd0;
      mcand  <= 64'd0;
      mplr   <= 32'd0;
      cnt    <= 5'd0;
      neg    <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (bus.start) begin
      neg <= neg_in;
      if (zero_op) begin
        hi_q   <= 32'd0;
        lo_q   <= 32'd0;
        done_q <= 1'b1;
        busy_q <= 1'b0;
        state  <= IDLE;
      end else begin
        acc    <= 64'd0;
        mcand  <= {32'd0, mag_a};
        mplr   <= mag_b;
        cnt    <= 5'd0;
        done_q <= 1'b0;
        busy_q <= 1'b1;
        state  <= RUN;
      end
    end else if (state == RUN) begin
      acc   <= acc_sum;
      mcand <= mcand << 1;
      mplr  <= mplr_shift;
      cnt   <= cnt + 5'd1;
      if (last) begin
        {hi_q, lo_q} <= product;
        done_q       <= 1'b1;
        busy_q       <= 1'b0;
        state        <= IDLE;
      end
    end
  end

  assign bus.Hi   = hi_q;
  assign bus.Lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: doc/mips_cpu_multiplier.md
Name: mips_cpu_multiplier

Overview:
- Iterative shift-add multiplier serving the ALU's MULT/MULTU instructions; the multiply counterpart of the iterative divider.
- Produces a 64-bit product split into Hi and Lo, which the CPU writes into the HI/LO registers.
- Retires one multiplier bit per cycle and signals completion with a sticky done flag.
- `sign` selects between signed (MULT) and unsigned (MULTU) operation.

Parameters:
- none (the width is fixed at 32 by the ISA)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; latches the operands and begins an operation
- sign  input  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled with start
- Multiplicand  input  32  operand A; sampled when start is high
- Multiplier  input  32  operand B; sampled when start is high
- Hi  output  32  product bits [63:32]
- Lo  output  32  product bits [31:0]
- busy  output  1  high while iterations are in progress
- done  output  1  high when Hi/Lo hold a valid result; sticky

Behaviour:
- Interface (already decided): one clock `clk`; `reset` is synchronous and active-high.
- Reset: Hi=0, Lo=0, done=0, busy=0, iteration counter=0, internal accumulators=0.
  - Reset has priority over start and takes effect mid-operation; any in-flight product is discarded.
- States: IDLE (busy=0) and RUN (busy=1).
  - done is independent of state: it clears on start and sets at completion.
- Start in either state (a start during RUN aborts the current operation and restarts):
  - done <= 0.
  - If sign=1: magA=|Multiplicand| and magB=|Multiplier|, each as 32-bit unsigned, so -2^31 maps to 0x8000_0000. Latch neg = sign & (A[31] ^ B[31]).
  - If sign=0: the magnitudes are the raw operands and neg=0.
  - Zero shortcut: if either operand is 0, then on the same edge Hi=0, Lo=0, done<=1, and the block stays in IDLE.
  - Otherwise: acc(64)=0, mcand(64)={32'b0,magA}, mplr(32)=magB, counter=0, enter RUN.
- RUN, each cycle:
  - If mplr[0]=1, acc <= acc + mcand (64-bit add, no carry out possible).
  - mcand <= mcand << 1; mplr <= mplr >> 1; counter += 1.
- Completion:
  - The iteration executing with counter==31 is the last. On that edge, {Hi,Lo} <= neg ? -(final acc) : final acc, using the two's complement of the 64-bit value that includes that cycle's add.
  - On the same edge: done<=1, state goes to IDLE.
- Latency: start edge E0; done and valid Hi/Lo are visible after edge E32 (32 cycles). With the zero shortcut, they are visible after E0.
- Result holding:
  - Hi/Lo/done hold their values until the next start or reset.
  - Hi/Lo keep the previous result during RUN and change only at completion or on a zero shortcut.
- Ignored inputs: sign and the operands are ignored except in a cycle where start is high.

Optional Feature:
- Macro: MIPS_CPU_MULT_EARLY_EXIT_EN.
- When defined:
  - Completion also occurs on the iteration whose post-shift mplr equals 0, i.e. when no set bits remain.
  - Latency is (index of the highest set bit of magB)+1 cycles. For example, B=1 gives done after E1, and B=0x0000_0100 gives done after E9.
  - The result, sign correction and done/busy semantics are identical.
- When undefined: every non-zero operation takes exactly 32 cycles.

Test Plan:
- Unsigned: start, sign=0, A=0x0000_0007, B=0x0000_0006 -> after 32 cycles, done=1, Hi=0x0, Lo=0x0000_002A; busy=1 in cycles 1-32.
- Unsigned max: A=B=0xFFFF_FFFF, sign=0 -> Hi=0xFFFF_FFFE, Lo=0x0000_0001.
- Signed: sign=1, A=0xFFFF_FFFD (-3), B=0x0000_0005 -> Hi=0xFFFF_FFFF, Lo=0xFFFF_FFF1; then A=B=0x8000_0000 -> Hi=0x4000_0000, Lo=0x0.
- Zero shortcut: A=0x1234_5678, B=0 -> done=1 and Hi=Lo=0 one edge after start; busy never asserts.
- Reset and restart:
  - Assert reset at cycle 10 of an operation -> next edge Hi=Lo=0, done=0, busy=0.
  - A second start at cycle 5 of an operation (A=2, B=3, sign=0) -> done only 32 cycles after the second start, Lo=6.
- Early exit (macro defined): A=0x10, B=0x100, sign=0 -> done after 9 cycles, Lo=0x1000; without the macro the same stimulus gives done after 32 cycles.
